alu_serial_ctrl: RTL and testbench
==================================

Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer that drives one existing 1-bit ALU slice (alu1) for WIDTH consecutive cycles to compute a full WIDTH-bit operation.
- Owns the operand and result shift registers, the carry flop, the bit counter and a start/ready/done handshake.
- Sits between the register-file read stage and writeback in the lab datapath. It is a low-area alternative to the ripple-chained alu32.

Parameters:
- WIDTH, 32, operand and result width in bits. Legal values are 2 to 64.
- CNT_W, $clog2(WIDTH+1), bit-counter width. Derived; never overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. 0 clears all state immediately.
- start  input  1  request pulse. Sampled only while ready=1.
- control  input  3  operation code, using the codebase alu1 encoding.
- A  input  WIDTH  operand A. Captured when start is accepted.
- B  input  WIDTH  operand B. Captured when start is accepted.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse; out and all flags are valid on this cycle.
- out  output  WIDTH  result. Held from done until the next accepted start.
- overflow  output  1  signed overflow. Meaningful for ADD and SUB; 0 for all other codes.
- zero  output  1  out == 0.
- negative  output  1  out[WIDTH-1].
- op_err  output  1  reserved control code was used. Valid with done.

Behaviour:
- Control encoding:
  - 2 = ADD, 3 = SUB.
  - 4 = AND, 5 = OR, 6 = NOR, 7 = XOR.
  - 0 and 1 are reserved.
- Reset (reset=0, asynchronous): state goes to IDLE.
  - ready=1; done=0; out=0; overflow=0; zero=0; negative=0; op_err=0.
  - Counter, carry flop and all shift registers cleared.
  - Reset asserted mid-RUN aborts the operation. No done pulse is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On start=1: latch A, B and control into a_sh, b_sh and op_q. Set cnt=0. Set carry_q = (control==SUB). Go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - ready=0.
  - Each cycle the slice sees A=a_sh[0], B=b_sh[0], carryin=carry_q, control=op_q.
  - On the clock edge:
    - res_sh shifts right with the slice out bit entering at the MSB.
    - a_sh and b_sh shift right.
    - carry_q takes the slice carryout.
    - cnt increments.
  - On the cycle where cnt==WIDTH-1:
    - Capture cin_msb = carry_q (carry into the MSB).
    - Capture cout_msb = slice carryout.
    - Go to DONE.
- DONE:
  - For exactly one cycle: done=1, ready=0.
  - out takes res_sh, or 0 if op_err.
  - overflow = (op_q is ADD or SUB) & (cin_msb ^ cout_msb).
  - zero and negative are computed from the registered out.
  - Next state is IDLE.
- Reserved control codes (0, 1):
  - The operation is still accepted and sequenced, so latency is unchanged.
  - At done: op_err=1, out=0, overflow=0, zero=1, negative=0.
- Latency: start accepted on edge t gives done high in the cycle after edge t+WIDTH, i.e. WIDTH+1 cycles after acceptance. Throughput is one operation per WIDTH+2 cycles.
- start while in RUN or DONE is ignored. It is not queued.
- A, B and control may change freely after acceptance; they have no effect on the in-flight operation.
- All outputs are registered. There is no combinational path from any input to any output.

Decomposition:
- Package alu_pkg holds:
  - ALU_ADD=3'd2, ALU_SUB=3'd3, ALU_AND=3'd4, ALU_OR=3'd5, ALU_NOR=3'd6, ALU_XOR=3'd7.
  - is_reserved_op() helper.
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Sub-module: one instance of the existing alu1 slice, instantiated unchanged.
- The controller contains no arithmetic of its own apart from the counter.

Test Plan (WIDTH=32):
- ADD, A=0x7FFFFFFF, B=0x00000001 -> done exactly 33 cycles after the accept edge; out=0x80000000, overflow=1, negative=1, zero=0.
- SUB, A=5, B=5 -> out=0x00000000, zero=1, overflow=0. Then SUB, A=0x80000000, B=1 -> out=0x7FFFFFFF, overflow=1, negative=0.
- XOR, A=0xF0F0F0F0, B=0xFFFF0000 -> out=0x0F0FF0F0, overflow=0. NOR, A=0, B=0 -> out=0xFFFFFFFF, negative=1.
- During RUN of ADD 3+4, pulse start with SUB 9-1 and change A, B -> ignored; out=7, ready returns only after done.
- Reset driven to 0 mid-RUN (cnt=10), asynchronously, between clock edges -> ready=1, out=0 and done=0 immediately without a clock edge; no done pulse follows. A new ADD 1+1 then gives out=2.
- control=1 (reserved), A=3, B=4 -> done after 33 cycles with op_err=1, out=0, zero=1, overflow=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 1-bit ALU slice and its bit-serial controller:
// operation codes, reserved-code helper and controller state encoding.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;
   localparam logic [2:0] ALU_AND = 3'd4;
   localparam logic [2:0] ALU_OR  = 3'd5;
   localparam logic [2:0] ALU_NOR = 3'd6;
   localparam logic [2:0] ALU_XOR = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Codes 0 and 1 have no operation assigned.
   function automatic logic is_reserved_op(input logic [2:0] op);
      return (op[2:1] == 2'b00);
   endfunction

   function automatic logic is_add_sub(input logic [2:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/alu1.sv
// One-bit ALU slice: add/subtract with carry chain plus bitwise logic ops.
// Subtraction expects the caller to seed carryin=1 on the LSB.
module alu1
   import alu_pkg::*;
(
   input  logic       A,
   input  logic       B,
   input  logic       carryin,
   input  logic [2:0] control,
   output logic       out,
   output logic       carryout
);

   logic b_eff;

   always_comb begin
      b_eff    = (control == ALU_SUB) ? ~B : B;
      out      = 1'b0;
      carryout = 1'b0;
      case (control)
         ALU_ADD, ALU_SUB: begin
            out      = A ^ b_eff ^ carryin;
            carryout = (A & b_eff) | (A & carryin) | (b_eff & carryin);
         end
         ALU_AND: out = A & B;
         ALU_OR:  out = A | B;
         ALU_NOR: out = ~(A | B);
         ALU_XOR: out = A ^ B;
         default: begin
            out      = 1'b0;
            carryout = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: streams WIDTH operand bits LSB-first through one alu1
// slice and presents the assembled result and flags with a one-cycle done pulse.
module alu_serial_ctrl
   import alu_pkg::*;
#(
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       control,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             overflow,
   output logic             zero,
   output logic             negative,
   output logic             op_err
);

   state_t           state_q;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [2:0]       op_q;
   logic             carry_q;
   logic [CNT_W-1:0] cnt;

   logic             slice_out;
   logic             slice_cout;
   logic             last_bit;
   logic             cin_msb;
   logic             cout_msb;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] res_final;

   alu1 u_slice (
      .A        (a_sh[0]),
      .B        (b_sh[0]),
      .carryin  (carry_q),
      .control  (op_q),
      .out      (slice_out),
      .carryout (slice_cout)
   );

   // On the last RUN cycle the slice is working on the MSB, so its carry-in
   // and carry-out are the pair that defines signed overflow.
   always_comb begin
      last_bit  = (cnt == CNT_W'(WIDTH - 1));
      cin_msb   = carry_q;
      cout_msb  = slice_cout;
      res_next  = {slice_out, res_sh[WIDTH-1:1]};
      res_final = is_reserved_op(op_q) ? '0 : res_next;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         op_q     <= '0;
         carry_q  <= 1'b0;
         cnt      <= '0;
         ready    <= 1'b1;
         done     <= 1'b0;
         out      <= '0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         negative <= 1'b0;
         op_err   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_sh    <= A;
                  b_sh    <= B;
                  op_q    <= control;
                  res_sh  <= '0;
                  cnt     <= '0;
                  carry_q <= (control == ALU_SUB);
                  ready   <= 1'b0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               res_sh  <= res_next;
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               carry_q <= slice_cout;
               cnt     <= cnt + CNT_W'(1);
               if (last_bit) begin
                  // Flags are derived from the value being written to out.
                  done     <= 1'b1;
                  out      <= res_final;
                  overflow <= is_add_sub(op_q) & (cin_msb ^ cout_msb);
                  zero     <= (res_final == '0);
                  negative <= res_final[WIDTH-1];
                  op_err   <= is_reserved_op(op_q);
                  state_q  <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b0;
               ready   <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               done    <= 1'b0;
               ready   <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl at WIDTH=32: result/flag values, latency,
// ignored start during RUN, asynchronous abort and reserved control codes.
module tb_alu_serial_ctrl;
   import alu_pkg::*;

   localparam int unsigned WIDTH = 32;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [2:0]       control = 3'd0;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             overflow;
   logic             zero;
   logic             negative;
   logic             op_err;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int check_cnt = 0;

   alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .control  (control),
      .A        (A),
      .B        (B),
      .ready    (ready),
      .done     (done),
      .out      (out),
      .overflow (overflow),
      .zero     (zero),
      .negative (negative),
      .op_err   (op_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_res(input string tag, input logic [31:0] e_out, input logic e_ov,
                            input logic e_z, input logic e_n, input logic e_err);
      check({tag, " out"}, 64'(out), 64'(e_out));
      check({tag, " overflow"}, 64'(overflow), 64'(e_ov));
      check({tag, " zero"}, 64'(zero), 64'(e_z));
      check({tag, " negative"}, 64'(negative), 64'(e_n));
      check({tag, " op_err"}, 64'(op_err), 64'(e_err));
   endtask

   // Issues one operation, checks done arrives exactly WIDTH edges after the
   // accept edge, and leaves the bench sampling in the done cycle.
   task automatic do_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, input string tag);
      int n;
      bit early;
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         @(posedge clock);
         #1;
         n++;
      end
      check({tag, " ready before start"}, 64'(ready), 64'd1);
      @(negedge clock);
      start   = 1'b1;
      control = c;
      A       = a;
      B       = b;
      @(posedge clock);
      #1;
      start = 1'b0;
      early = 1'b0;
      for (int i = 1; i <= WIDTH; i++) begin
         @(posedge clock);
         #1;
         if (i < WIDTH && done === 1'b1) early = 1'b1;
         if (inject && i == 5) begin
            start   = 1'b1;
            control = ALU_SUB;
            A       = 32'd9;
            B       = 32'd1;
         end
         if (inject && i == 6) start = 1'b0;
         if (inject && i == 16) check({tag, " ready in RUN"}, 64'(ready), 64'd0);
      end
      check({tag, " no early done"}, 64'(early), 64'd0);
      check({tag, " done at latency"}, 64'(done), 64'd1);
      check({tag, " ready low at done"}, 64'(ready), 64'd0);
   endtask

   task automatic after_done(input string tag);
      @(posedge clock);
      #1;
      check({tag, " done one cycle"}, 64'(done), 64'd0);
      check({tag, " ready after done"}, 64'(ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen;

      #12;
      check("reset ready", 64'(ready), 64'd1);
      check("reset done", 64'(done), 64'd0);
      check_res("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      do_op(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add ovf");
      check_res("add ovf", 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      after_done("add ovf");
      check("add ovf out held", 64'(out), 64'h8000_0000);

      do_op(ALU_SUB, 32'd5, 32'd5, 1'b0, "sub zero");
      check_res("sub zero", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      after_done("sub zero");

      do_op(ALU_SUB, 32'h8000_0000, 32'd1, 1'b0, "sub ovf");
      check_res("sub ovf", 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
      after_done("sub ovf");

      do_op(ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0, "xor");
      check_res("xor", 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0, 1'b0);
      after_done("xor");

      do_op(ALU_NOR, 32'h0, 32'h0, 1'b0, "nor");
      check_res("nor", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
      after_done("nor");

      do_op(ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, "and");
      check_res("and", 32'h0F00_0F00, 1'b0, 1'b0, 1'b0, 1'b0);
      after_done("and");

      do_op(ALU_OR, 32'h0000_00F0, 32'h0000_000F, 1'b0, "or");
      check_res("or", 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0);
      after_done("or");

      do_op(ALU_ADD, 32'd3, 32'd4, 1'b1, "ignored start");
      check_res("ignored start", 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      after_done("ignored start");

      // Asynchronous abort at cnt=10, asserted between clock edges.
      @(negedge clock);
      start   = 1'b1;
      control = ALU_ADD;
      A       = 32'd100;
      B       = 32'd200;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      check("abort ready", 64'(ready), 64'd1);
      check("abort out", 64'(out), 64'd0);
      check("abort done", 64'(done), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (done === 1'b1) seen = 1'b1;
      end
      check("abort no done", 64'(seen), 64'd0);
      check("abort idle ready", 64'(ready), 64'd1);

      do_op(ALU_ADD, 32'd1, 32'd1, 1'b0, "add after abort");
      check_res("add after abort", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      after_done("add after abort");

      do_op(3'd1, 32'd3, 32'd4, 1'b0, "reserved");
      check_res("reserved", 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      after_done("reserved");

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
